// File: rtl/tender_pkg.sv
// rtl/tender_pkg.sv - shared constants, group-index type and shift helper for the TENDER dequantizer
//
// Purpose : constants common to the dequantizer top and its lane shifter.
//           DW      - signed quantized element width
//           NUM_GRP - channel groups; group 0 is the outlier group (largest scale)
//           GIW     - group-index width
//           OW      - rescaled element width (DW + NUM_GRP - 1, never overflows)
//           shamt() - left-shift amount that brings group g onto the group-0 scale
package tender_pkg;

  localparam int DW      = 8;
  localparam int NUM_GRP = 4;
  localparam int GIW     = $clog2(NUM_GRP);
  localparam int OW      = DW + NUM_GRP - 1;

  typedef logic [GIW-1:0] grp_idx_t;

  function automatic int shamt(input grp_idx_t g);
    return NUM_GRP - 1 - int'(g);
  endfunction

endpackage

// File: rtl/tender_lane_shift.sv
// rtl/tender_lane_shift.sv - per-lane sign-extend, group clamp and rescale shift
//
// Purpose : combinational rescale of one int8 element to the outlier-group scale.
// Ports   : q   in  DW  signed quantized element
//           g   in  GIW group index of this lane's channel
//           y   out OW  sign_extend(q) <<< (NUM_GRP-1-g)
//           oor out 1   group index was out of range and got clamped
module tender_lane_shift
  import tender_pkg::*;
(
  input  logic [DW-1:0] q,
  input  grp_idx_t      g,
  output logic [OW-1:0] y,
  output logic          oor
);

  logic [GIW:0]         g_wide;
  grp_idx_t             g_eff;
  logic signed [OW-1:0] q_ext;

  always_comb begin
    // Compare one bit wider than the index so the range check is meaningful
    // whether or not NUM_GRP is a power of two.
    g_wide = {1'b0, g};
    oor    = (g_wide >= (GIW+1)'(NUM_GRP));
    g_eff  = oor ? grp_idx_t'(NUM_GRP - 1) : g;
    q_ext  = {{(OW-DW){q[DW-1]}}, q};
    y      = q_ext <<< shamt(g_eff);
  end

endmodule

// File: rtl/tender_group_dequant.sv
// rtl/tender_group_dequant.sv - TENDER channel-group dequantizer, two-stage stream pipeline
//
// Purpose : accepts rows of CH int8 channels, VEC per beat, looks up each channel's
//           group, rescales to the outlier-group scale and streams the result out.
// Ports   : clk, rstn                   clock, async active-low reset
//           cfg_we/cfg_addr/cfg_grp     group-table write (honoured only when idle)
//           in_valid/in_ready/in_data   input beat, lane i at [i*DW +: DW]
//           out_valid/out_ready/out_data/out_last  output beat, lane i at [i*OW +: OW]
//           row_cnt                     completed rows emitted (wraps)
//           busy                        row in progress or pipeline non-empty
//           err                         sticky: rejected config write or clamped group
module tender_group_dequant
  import tender_pkg::*;
#(
  parameter int VEC = 4,
  parameter int CH  = 16,
  parameter int CHW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_addr,
  input  grp_idx_t          cfg_grp,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC*DW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC*OW-1:0] out_data,
  output logic              out_last,
  output logic [15:0]       row_cnt,
  output logic              busy,
  output logic              err
);

  grp_idx_t          tbl [CH];
  logic [CHW-1:0]    ch_ptr;

  logic              s1_valid;
  logic [VEC*DW-1:0] s1_data;
  grp_idx_t          s1_grp [VEC];
  logic              s1_last;

  logic [VEC*OW-1:0] lane_y;
  logic [VEC-1:0]    lane_oor;

  logic              s1_adv;
  logic              s2_adv;
  logic              accept;
  logic              cfg_apply;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rstn && s1_adv;
  assign accept   = in_valid && in_ready;
  assign busy     = (ch_ptr != '0) || s1_valid || out_valid;
  // An accepted beat makes the block busy in the same cycle, so a write that
  // coincides with the first beat of a row is rejected too.
  assign cfg_apply = cfg_we && !busy && !accept;

  for (genvar i = 0; i < VEC; i++) begin : g_lane
    tender_lane_shift u_shift (
      .q   (s1_data[i*DW +: DW]),
      .g   (s1_grp[i]),
      .y   (lane_y[i*OW +: OW]),
      .oor (lane_oor[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CH; c++) tbl[c] <= '0;
      ch_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      for (int i = 0; i < VEC; i++) s1_grp[i] <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      row_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      if (cfg_apply) tbl[cfg_addr] <= cfg_grp;

      err <= err || (cfg_we && !cfg_apply) || (s1_valid && s2_adv && (|lane_oor));

      if (accept) begin
        ch_ptr <= (ch_ptr == CHW'(CH - VEC)) ? '0 : ch_ptr + CHW'(VEC);
      end

      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data <= in_data;
          for (int i = 0; i < VEC; i++) s1_grp[i] <= tbl[ch_ptr + CHW'(i)];
          s1_last <= (ch_ptr == CHW'(CH - VEC));
        end
      end

      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= lane_y;
          out_last <= s1_last;
        end
      end

      if (out_valid && out_ready && out_last) row_cnt <= row_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tender_group_dequant.sv
// tb/tb_tender_group_dequant.sv - self-checking bench for tender_group_dequant
module tb_tender_group_dequant;

  localparam int VEC = 4;
  localparam int DW  = 8;
  localparam int OW  = 11;
  localparam int CH  = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [1:0]        cfg_grp;
  logic              in_valid;
  logic              in_ready;
  logic [VEC*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [VEC*OW-1:0] out_data;
  logic              out_last;
  logic [15:0]       row_cnt;
  logic              busy;
  logic              err;

  tender_group_dequant #(.VEC(VEC), .CH(CH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_grp   (cfg_grp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .row_cnt   (row_cnt),
    .busy      (busy),
    .err       (err)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [VEC*OW-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [7:0]        gpat;
    logic [VEC*DW-1:0] din;
    logic [VEC*OW-1:0] dexp;
  } vec_t;

  beat_t             sb [$];
  logic [VEC*OW-1:0] outq [$];
  bit                lastq [$];
  int                hs_cyc [$];
  int                tbl_m [CH];
  int                mch;
  int                rows_m;
  int                n_checks;
  int                n_fail;
  int                ncyc;
  int                ready_mode;
  int                rdy_ph;
  logic [VEC*OW-1:0] last_out;
  logic              last_last;
  logic              stalled;
  logic [VEC*OW-1:0] st_data;
  logic              st_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: element value times 2^(NUM_GRP-1-group), truncated to OW bits.
  function automatic logic [VEC*OW-1:0] expect_beat(input logic [VEC*DW-1:0] d, input int ch);
    logic [VEC*OW-1:0] r;
    for (int i = 0; i < VEC; i++) begin
      int q;
      int v;
      q = int'($signed(d[i*DW +: DW]));
      v = q * (1 << (3 - tbl_m[ch + i]));
      r[i*OW +: OW] = v[OW-1:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] pack8(input int a0, input int a1, input int a2, input int a3);
    logic [31:0] r;
    r[7:0] = a0[7:0]; r[15:8] = a1[7:0]; r[23:16] = a2[7:0]; r[31:24] = a3[7:0];
    return r;
  endfunction

  function automatic logic [43:0] pack11(input int a0, input int a1, input int a2, input int a3);
    logic [43:0] r;
    r[10:0] = a0[10:0]; r[21:11] = a1[10:0]; r[32:22] = a2[10:0]; r[43:33] = a3[10:0];
    return r;
  endfunction

  function automatic logic [7:0] gp(input int g0, input int g1, input int g2, input int g3);
    logic [7:0] r;
    r[1:0] = g0[1:0]; r[3:2] = g1[1:0]; r[5:4] = g2[1:0]; r[7:6] = g3[1:0];
    return r;
  endfunction

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      stalled = 1'b0;
    end else begin
      ncyc++;
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, st_data);
        chk("hold_last", out_last, st_last);
      end
      chk("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", out_data, 0);
          chk("unexpected_beat_sb", 1, 0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
          if (e.last) rows_m++;
        end
        last_out  = out_data;
        last_last = out_last;
        outq.push_back(out_data);
        lastq.push_back(out_last);
        hs_cyc.push_back(ncyc);
      end
      stalled = out_valid && !out_ready;
      st_data = out_data;
      st_last = out_last;
      if (in_valid && in_ready) begin
        sb.push_back('{data: expect_beat(in_data, mch), last: (mch == CH - VEC)});
        mch = (mch + VEC) % CH;
      end
    end
  end

  // Downstream ready pattern generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rdy_ph == 0 || rdy_ph == 3);
          rdy_ph    = (rdy_ph + 1) % 4;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int g, input bit expect_apply);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_grp  = 2'(g);
    tick();
    cfg_we = 1'b0;
    if (expect_apply) tbl_m[a] = g;
  endtask

  task automatic program_tbl(input logic [7:0] gpat);
    for (int c = 0; c < CH; c++) cfg_write(c, int'(gpat[(c % 4)*2 +: 2]), 1);
  endtask

  task automatic program_rand();
    for (int c = 0; c < CH; c++) cfg_write(c, $urandom_range(0, 3), 1);
  endtask

  task automatic send_beat(input logic [VEC*DW-1:0] d);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
  endtask

  task automatic drain();
    bit ok;
    ok       = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", sb.size(), 0);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    mch    = 0;
    rows_m = 0;
    for (int c = 0; c < CH; c++) tbl_m[c] = 0;
  endtask

  vec_t        vecs [5];
  logic [15:0] base;

  initial begin
    n_checks = 0; n_fail = 0; ncyc = 0; ready_mode = 0; rdy_ph = 0;
    stalled = 1'b0; last_out = '0; last_last = 1'b0;
    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_grp = '0;
    in_valid = 1'b0; in_data = '0;
    clear_model();

    vecs[0] = '{gp(0,1,2,3), pack8(3,3,3,3),         pack11(24,12,6,3)};
    vecs[1] = '{gp(0,0,0,0), pack8(-128,127,-1,0),   pack11(-1024,1016,-8,0)};
    vecs[2] = '{gp(3,3,3,3), pack8(-128,127,-1,0),   pack11(-128,127,-1,0)};
    vecs[3] = '{gp(1,2,0,3), pack8(-5,100,-128,127), pack11(-20,200,-1024,127)};
    vecs[4] = '{gp(2,1,3,0), pack8(-1,-64,50,1),     pack11(-2,-256,50,8)};

    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_row_cnt", row_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;
    tick();
    chk("in_ready_after_reset", in_ready, 1);

    // Latency of the first beat, then the rest of the row.
    program_tbl(gp(0,1,2,3));
    in_valid = 1'b1;
    in_data  = pack8(3,3,3,3);
    @(negedge clk);
    chk("lat_accept", in_ready, 1);
    chk("lat_c0", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1", out_valid, 0);
    @(negedge clk);
    chk("lat_c2", out_valid, 1);
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) send_beat(pack8(3,3,3,3));
    drain();
    chk("t1_data", last_out, pack11(24,12,6,3));
    chk("t1_last", last_last, 1);
    chk("t1_rows", row_cnt, 1);

    // Table-driven vectors: one full row of identical beats per record.
    for (int v = 0; v < 5; v++) begin
      program_tbl(vecs[v].gpat);
      for (int b = 0; b < 4; b++) send_beat(vecs[v].din);
      drain();
      chk("vec_data", last_out, vecs[v].dexp);
      chk("vec_last", last_last, 1);
      chk("vec_rows", row_cnt, 16'(2 + v));
    end

    // Backpressure with the 1,0,0,1 ready pattern over two rows.
    program_rand();
    base = row_cnt;
    rdy_ph = 0;
    ready_mode = 1;
    for (int b = 0; b < 8; b++) send_beat($urandom);
    drain();
    ready_mode = 0;
    tick();
    chk("bp_rows", 16'(row_cnt - base), 2);
    chk("bp_rows_model", row_cnt, 16'(rows_m));

    // Config write during a row is dropped; the same write when idle lands.
    chk("err_pre", err, 0);
    program_tbl(gp(0,0,0,0));
    outq.delete();
    send_beat(pack8(1,1,1,1));
    in_valid = 1'b0;
    chk("busy_mid_row", busy, 1);
    cfg_write(5, 2, 0);
    chk("err_cfg_busy", err, 1);
    for (int b = 0; b < 3; b++) send_beat(pack8(1,1,1,1));
    drain();
    if (outq.size() == 4) chk("ch5_old_grp", outq[1][OW +: OW], 8);
    else chk("cfg_busy_beats", outq.size(), 4);
    cfg_write(5, 2, 1);
    chk("err_sticky", err, 1);
    outq.delete();
    for (int b = 0; b < 4; b++) send_beat(pack8(1,1,1,1));
    drain();
    if (outq.size() == 4) chk("ch5_new_grp", outq[1][OW +: OW], 2);
    else chk("cfg_idle_beats", outq.size(), 4);

    // Reset in the middle of a row.
    program_tbl(gp(1,2,3,1));
    send_beat($urandom);
    send_beat($urandom);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    clear_model();
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_row_cnt", row_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    tick();
    rstn = 1'b1;
    tick();
    outq.delete();
    lastq.delete();
    for (int b = 0; b < 4; b++) send_beat(pack8(1,1,1,1));
    drain();
    chk("post_rst_data", last_out, pack11(8,8,8,8));
    chk("post_rst_beats", lastq.size(), 4);
    if (lastq.size() == 4) chk("post_rst_last3", lastq[2], 0);
    chk("post_rst_last4", last_last, 1);
    chk("post_rst_rows", row_cnt, 1);

    // Config write in the same cycle as the first beat of a row.
    chk("err_clear", err, 0);
    outq.delete();
    cfg_we   = 1'b1;
    cfg_addr = 4'd0;
    cfg_grp  = 2'd3;
    in_valid = 1'b1;
    in_data  = pack8(1,1,1,1);
    @(negedge clk);
    chk("coinc_accept", in_ready, 1);
    @(posedge clk); #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    chk("err_coinc", err, 1);
    for (int b = 0; b < 3; b++) send_beat(pack8(1,1,1,1));
    drain();
    if (outq.size() == 4) chk("ch0_unchanged", outq[0][0 +: OW], 8);
    else chk("coinc_beats", outq.size(), 4);

    // Three back-to-back rows with in_valid held high.
    program_rand();
    outq.delete();
    lastq.delete();
    hs_cyc.delete();
    base = row_cnt;
    for (int b = 0; b < 12; b++) send_beat($urandom);
    drain();
    @(negedge clk);
    chk("b2b_busy_idle", busy, 0);
    @(posedge clk); #1;
    chk("b2b_count", hs_cyc.size(), 12);
    if (hs_cyc.size() == 12) begin
      chk("b2b_span", hs_cyc[11] - hs_cyc[0], 11);
      for (int j = 0; j < 12; j++) chk("b2b_last", lastq[j], (j % 4) == 3);
    end
    chk("b2b_rows", 16'(row_cnt - base), 3);

    // Randomized rows with random gaps and random downstream stalls.
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      program_rand();
      for (int b = 0; b < 4; b++) begin
        int gap;
        send_beat($urandom);
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          in_valid = 1'b0;
          repeat (gap) tick();
        end
      end
      drain();
    end
    ready_mode = 0;
    tick();
    chk("rand_rows", row_cnt, 16'(rows_m));
    chk("rand_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
